io_bus_fabric: RTL

- Parametrised memory-mapped IO interconnect between the CPU data port and N peripheral slaves.
- Replaces the per-peripheral ad-hoc valid/ready decode and the priority read-mux at SoC top.
- Decodes the address against per-slave base/mask windows and issues a single held valid to the selected slave.
- Registers the slave response back to the CPU, answers unmatched addresses itself and aborts hung slaves with a watchdog timeout plus fault flag.

---
 rtl/io_bus_fabric.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/io_bus_fabric.sv
// rtl/io_bus_fabric.sv - memory-mapped IO interconnect between CPU data port and N slaves
module io_bus_fabric #(
  parameter int NUM_SLAVES                          = 8,
  parameter int ADDR_W                              = 32,
  parameter int DATA_W                              = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] BASE_ADDRS = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] ADDR_MASKS = '0,
  parameter int TIMEOUT_CYCLES                      = 255,
  parameter int FAULT_ON_UNMATCHED                  = 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         cpu_valid,
  input  logic [ADDR_W-1:0]            cpu_addr,
  input  logic [DATA_W-1:0]            cpu_wdata,
  input  logic [DATA_W/8-1:0]          cpu_wstrb,
  output logic                         cpu_ready,
  output logic [DATA_W-1:0]            cpu_rdata,
  output logic                         cpu_fault,
  output logic [NUM_SLAVES-1:0]        s_valid,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  output logic [DATA_W/8-1:0]          s_wstrb,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]        s_ready,
  output logic [15:0]                  fault_cnt
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
  localparam logic [NUM_SLAVES-1:0] ONE = 1;
  localparam logic UNM_FAULT = (FAULT_ON_UNMATCHED != 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP
  } state_t;

  state_t                r_state;
  logic [WD_W-1:0]       r_wd;
  logic [NUM_SLAVES-1:0] w_match;
  logic [NUM_SLAVES-1:0] w_onehot;
  logic [DATA_W-1:0]     w_sel_rdata;
  logic                  w_sel_ready;

  // Window match per slave: masked address equals masked base
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_dec
      assign w_match[gi] = ((cpu_addr & ADDR_MASKS[gi*ADDR_W +: ADDR_W]) ==
                            (BASE_ADDRS[gi*ADDR_W +: ADDR_W] & ADDR_MASKS[gi*ADDR_W +: ADDR_W]));
    end
  endgenerate

  // Isolate lowest set bit so the lowest index wins on overlapping windows
  assign w_onehot = w_match & (~w_match + ONE);

  // Ready only counts from the slave currently holding s_valid
  assign w_sel_ready = |(s_ready & s_valid);

  // Read-data mux driven by the one-hot s_valid held during REQ
  always_comb begin
    w_sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (s_valid[i]) begin
        w_sel_rdata = w_sel_rdata | s_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Transaction FSM with registered slave request, CPU response, watchdog and fault counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_wd      <= '0;
      s_valid   <= '0;
      s_addr    <= '0;
      s_wdata   <= '0;
      s_wstrb   <= '0;
      cpu_ready <= 1'b0;
      cpu_rdata <= '0;
      cpu_fault <= 1'b0;
      fault_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          cpu_ready <= 1'b0;
          cpu_rdata <= '0;
          cpu_fault <= 1'b0;
          if (cpu_valid) begin
            s_addr  <= cpu_addr;
            s_wdata <= cpu_wdata;
            s_wstrb <= cpu_wstrb;
            if (|w_match) begin
              s_valid <= w_onehot;
              r_wd    <= WD_W'(1);
              r_state <= ST_REQ;
            end else begin
              // Unmatched address is answered locally, no slave sees it
              cpu_ready <= 1'b1;
              cpu_rdata <= '0;
              cpu_fault <= UNM_FAULT;
              if (UNM_FAULT && fault_cnt != 16'hFFFF) begin
                fault_cnt <= fault_cnt + 16'd1;
              end
              r_state <= ST_RESP;
            end
          end
        end
        ST_REQ: begin
          if (w_sel_ready) begin
            // Ready beats a simultaneous watchdog expiry
            s_valid   <= '0;
            cpu_ready <= 1'b1;
            cpu_rdata <= (|s_wstrb) ? '0 : w_sel_rdata;
            cpu_fault <= 1'b0;
            r_wd      <= '0;
            r_state   <= ST_RESP;
          end else if (r_wd == WD_MAX) begin
            s_valid   <= '0;
            cpu_ready <= 1'b1;
            cpu_rdata <= '0;
            cpu_fault <= 1'b1;
            if (fault_cnt != 16'hFFFF) begin
              fault_cnt <= fault_cnt + 16'd1;
            end
            r_wd    <= '0;
            r_state <= ST_RESP;
          end else begin
            r_wd <= r_wd + WD_W'(1);
          end
        end
        ST_RESP: begin
          cpu_ready <= 1'b0;
          cpu_rdata <= '0;
          cpu_fault <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: begin
          s_valid   <= '0;
          cpu_ready <= 1'b0;
          cpu_rdata <= '0;
          cpu_fault <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
